// File: rtl/alu_lhs_shift_sequencer.sv
// Multi-step controller for the registered single-step ALU LHS shifter.
// Walks one shift/rotate command through LOAD/SHIFT/CAPTURE, feeding the shifter output back as LHS.
module alu_lhs_shift_sequencer #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned COUNT_WIDTH = 3
) (
    input  logic                   AluClock,
    input  logic                   Reset,
    input  logic                   Start,
    input  logic [2:0]             Op,
    input  logic [COUNT_WIDTH-1:0] Count,
    input  logic [DATA_WIDTH-1:0]  Operand,
    input  logic                   CarryFlagIn,
    output logic                   Busy,
    output logic                   Done,
    output logic [DATA_WIDTH-1:0]  Result,
    output logic                   CarryOut,
    output logic [DATA_WIDTH-1:0]  LHS_Out,
    output logic                   AC4_LHS0,
    output logic                   AC5_LHS1,
    output logic                   LCarryIn,
    input  logic [DATA_WIDTH-1:0]  Shift_In,
    input  logic                   LCarryOut_In
);

    localparam int unsigned MODE_WIDTH = 2;

    localparam logic [2:0] OP_SHL = 3'b000;
    localparam logic [2:0] OP_SHR = 3'b001;
    localparam logic [2:0] OP_ROL = 3'b010;
    localparam logic [2:0] OP_ROR = 3'b011;
    localparam logic [2:0] OP_ASR = 3'b100;
    localparam logic [2:0] OP_RCL = 3'b101;
    localparam logic [2:0] OP_RCR = 3'b110;
    localparam logic [2:0] OP_CLR = 3'b111;

    localparam logic [MODE_WIDTH-1:0] MODE_PASS  = 2'b00;
    localparam logic [MODE_WIDTH-1:0] MODE_LEFT  = 2'b01;
    localparam logic [MODE_WIDTH-1:0] MODE_RIGHT = 2'b10;
    localparam logic [MODE_WIDTH-1:0] MODE_ZERO  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_SHIFT   = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next;

    logic [2:0]              r_op;
    logic [COUNT_WIDTH-1:0]  r_count;
    logic [COUNT_WIDTH-1:0]  r_rem;
    logic [DATA_WIDTH-1:0]   r_operand;
    logic                    r_cf;
    logic                    r_first;

    logic                    r_busy;
    logic                    r_done;
    logic [DATA_WIDTH-1:0]   r_result;
    logic                    r_carry;
    logic [MODE_WIDTH-1:0]   r_mode;

    logic [MODE_WIDTH-1:0]   w_mode_next;
    logic [DATA_WIDTH-1:0]   w_lhs;
    logic                    w_cin;

    // State register
    always_ff @(posedge AluClock or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state, next shifter mode, and shifter LHS/carry-in selection
    always_comb begin
        w_next      = r_state;
        w_mode_next = MODE_PASS;
        w_lhs       = '0;
        w_cin       = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (Start) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_lhs = r_operand;
                if (r_rem != '0) begin
                    w_next = S_SHIFT;
                end else begin
                    w_next = S_CAPTURE;
                end
            end
            S_SHIFT: begin
                w_lhs = Shift_In;
                if (r_rem == COUNT_WIDTH'(1)) begin
                    w_next = S_CAPTURE;
                end
                unique case (r_op)
                    OP_ROL, OP_ASR: w_cin = Shift_In[DATA_WIDTH-1];
                    OP_ROR:         w_cin = Shift_In[0];
                    OP_RCL, OP_RCR: w_cin = r_first ? r_cf : LCarryOut_In;
                    default:        w_cin = 1'b0;
                endcase
            end
            S_CAPTURE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase

        // Mode is registered, so it is computed for the state being entered
        if (w_next == S_SHIFT) begin
            unique case (r_op)
                OP_SHL, OP_ROL, OP_RCL:         w_mode_next = MODE_LEFT;
                OP_SHR, OP_ROR, OP_ASR, OP_RCR: w_mode_next = MODE_RIGHT;
                OP_CLR:                         w_mode_next = MODE_ZERO;
                default:                        w_mode_next = MODE_PASS;
            endcase
        end
    end

    // Command latch, step counter and result capture
    always_ff @(posedge AluClock or posedge Reset) begin
        if (Reset) begin
            r_op      <= '0;
            r_count   <= '0;
            r_rem     <= '0;
            r_operand <= '0;
            r_cf      <= 1'b0;
            r_first   <= 1'b0;
            r_result  <= '0;
            r_carry   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_op      <= Op;
                        r_count   <= Count;
                        r_operand <= Operand;
                        r_cf      <= CarryFlagIn;
                        r_rem     <= (Op == OP_CLR) ? COUNT_WIDTH'(1) : Count;
                    end
                end
                S_LOAD: begin
                    r_first <= 1'b1;
                end
                S_SHIFT: begin
                    r_rem   <= r_rem - COUNT_WIDTH'(1);
                    r_first <= 1'b0;
                end
                S_CAPTURE: begin
                    r_result <= Shift_In;
                    // A zero-count command leaves the carry flag untouched
                    if ((r_count == '0) && (r_op != OP_CLR)) begin
                        r_carry <= r_cf;
                    end else begin
                        r_carry <= LCarryOut_In;
                    end
                end
                default: begin
                    r_rem <= '0;
                end
            endcase
        end
    end

    // Registered handshake and shifter mode
    always_ff @(posedge AluClock or posedge Reset) begin
        if (Reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_mode <= MODE_PASS;
        end else begin
            r_busy <= (w_next != S_IDLE);
            r_done <= (r_state == S_CAPTURE);
            r_mode <= w_mode_next;
        end
    end

    assign Busy     = r_busy;
    assign Done     = r_done;
    assign Result   = r_result;
    assign CarryOut = r_carry;
    assign AC4_LHS0 = r_mode[0];
    assign AC5_LHS1 = r_mode[1];
    assign LHS_Out  = w_lhs;
    assign LCarryIn = w_cin;

endmodule

// File: tb/tb_alu_lhs_shift_sequencer.sv
// Bench for alu_lhs_shift_sequencer: shifter model, directed plus random commands, queue scoreboard.
module tb_alu_lhs_shift_sequencer;

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2:0]    op;
    logic [CW-1:0] count;
    logic [DW-1:0] operand;
    logic          cf_in;
    logic          busy, done, carry_out, ac4, ac5, lcin;
    logic [DW-1:0] result, lhs_out;
    logic [DW-1:0] sh_q;
    logic          sh_c;

    always #5 clk = ~clk;

    alu_lhs_shift_sequencer #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .AluClock(clk), .Reset(rst), .Start(start), .Op(op), .Count(count),
        .Operand(operand), .CarryFlagIn(cf_in), .Busy(busy), .Done(done),
        .Result(result), .CarryOut(carry_out), .LHS_Out(lhs_out),
        .AC4_LHS0(ac4), .AC5_LHS1(ac5), .LCarryIn(lcin),
        .Shift_In(sh_q), .LCarryOut_In(sh_c)
    );

    // Registered single-step shifter the sequencer drives
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q <= '0;
            sh_c <= 1'b0;
        end else begin
            case ({ac5, ac4})
                2'b00: begin sh_q <= lhs_out;                  sh_c <= 1'b0;       end
                2'b01: begin sh_q <= {lhs_out[DW-2:0], lcin};  sh_c <= lhs_out[DW-1]; end
                2'b10: begin sh_q <= {lcin, lhs_out[DW-1:1]};  sh_c <= lhs_out[0]; end
                default: begin sh_q <= '0;                     sh_c <= 1'b0;       end
            endcase
        end
    end

    typedef struct {
        logic [DW-1:0] res;
        logic          c;
        int unsigned   done_cyc;
    } exp_t;

    exp_t          sb[$];
    int            errors = 0;
    int            checks = 0;
    int unsigned   cyc = 0;
    int unsigned   win_s = 0;
    int unsigned   win_e = 0;
    logic [DW-1:0] last_res = '0;
    logic          last_c = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Result and carry computed step by step with plain integer arithmetic
    function automatic logic [DW:0] ref_model(input logic [2:0] o, input int n,
                                              input logic [DW-1:0] x, input logic cf);
        int unsigned v = x;
        int unsigned c = cf;
        int unsigned b;
        if (o == 3'd7) return '0;
        for (int i = 0; i < n; i++) begin
            case (o)
                3'd0: begin c = v / 128; v = (v * 2) % 256; end
                3'd1: begin c = v % 2;   v = v / 2; end
                3'd2: begin c = v / 128; v = (v * 2) % 256 + c; end
                3'd3: begin c = v % 2;   v = v / 2 + 128 * c; end
                3'd4: begin c = v % 2;   v = v / 2 + (v / 128) * 128; end
                3'd5: begin b = c; c = v / 128; v = (v * 2) % 256 + b; end
                default: begin b = c; c = v % 2; v = v / 2 + 128 * b; end
            endcase
        end
        return {1'(c), 8'(v)};
    endfunction

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            errors++;
            checks++;
            $display("FAIL wait_idle: busy stuck at %0b expected 0", busy);
        end
    endtask

    task automatic issue(input logic [2:0] o, input int n, input logic [DW-1:0] x, input logic cf);
        logic [DW:0] r;
        int unsigned eff;
        wait_idle();
        op = o; count = CW'(n); operand = x; cf_in = cf; start = 1'b1;
        eff = (o == 3'd7) ? 1 : n;
        r = ref_model(o, n, x, cf);
        win_s = cyc + 1;
        win_e = cyc + 1 + eff + 2;
        sb.push_back('{res: r[DW-1:0], c: r[DW], done_cyc: win_e});
        @(negedge clk);
        start = 1'b0;
        op = 3'($urandom); count = CW'($urandom); operand = DW'($urandom); cf_in = 1'($urandom);
    endtask

    // Monitor: sampled 1 time unit after each active edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst) continue;
            check("busy", 32'(busy), 32'(cyc >= win_s && cyc < win_e));
            if (done) begin
                if (sb.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected_done at cycle %0d: got done=1 expected 0", cyc);
                end else begin
                    e = sb.pop_front();
                    check("result", 32'(result), 32'(e.res));
                    check("carry", 32'(carry_out), 32'(e.c));
                    check("done_cycle", cyc, e.done_cyc);
                    last_res = e.res;
                    last_c = e.c;
                end
            end else begin
                check("hold_result", 32'(result), 32'(last_res));
                check("hold_carry", 32'(carry_out), 32'(last_c));
                if (sb.size() > 0 && cyc > sb[0].done_cyc) begin
                    errors++;
                    checks++;
                    $display("FAIL missing_done at cycle %0d: got none expected at %0d", cyc, sb[0].done_cyc);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_result"}, 32'(result), 0);
        check({tag, "_carry"}, 32'(carry_out), 0);
        check({tag, "_lhs"}, 32'(lhs_out), 0);
        check({tag, "_ac4"}, 32'(ac4), 0);
        check({tag, "_ac5"}, 32'(ac5), 0);
        check({tag, "_lcin"}, 32'(lcin), 0);
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; op = '0; count = '0; operand = '0; cf_in = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        issue(3'd0, 1, 8'h81, 1'b0);
        issue(3'd3, 3, 8'h01, 1'b0);
        issue(3'd4, 3, 8'h80, 1'b1);
        issue(3'd5, 2, 8'h80, 1'b1);
        issue(3'd1, 0, 8'h55, 1'b1);
        issue(3'd7, 5, 8'hFF, 1'b1);

        // Start pulsed while busy must be ignored
        issue(3'd2, 6, 8'h3C, 1'b0);
        @(negedge clk);
        start = 1'b1; op = 3'd7; count = 3'd1; operand = 8'hA5;
        @(negedge clk);
        start = 1'b1; op = 3'd0; count = 3'd0;
        @(negedge clk);
        start = 1'b0;

        // Back-to-back: second Start lands in the Done cycle
        issue(3'd6, 4, 8'h96, 1'b1);
        issue(3'd0, 2, 8'hC3, 1'b0);

        // Reset during SHIFT abandons the command
        issue(3'd2, 7, 8'hAA, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        sb.delete();
        win_s = 0; win_e = 0; last_res = '0; last_c = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        issue(3'd0, 7, 8'h01, 1'b0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) != 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            issue(3'($urandom_range(0, 7)), int'($urandom_range(0, 7)), DW'($urandom), 1'($urandom));
        end

        n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
